// File: rtl/bp_fe_bht_update_queue_if.sv
// Handshake bundle between the backend branch-resolution path, the BHT
// update queue and the BHT write port. The master is the party producing
// updates and controlling stall/flush; the slave is the queue itself.
interface bp_fe_bht_update_queue_if #(
    parameter int bht_idx_width_p = 8,
    parameter int els_p           = 4
);
    localparam int ptr_width_lp = $clog2(els_p);

    // Update stream from the backend.
    logic                       v_i;
    logic [bht_idx_width_p-1:0] idx_i;
    logic                       correct_i;
    logic                       ready_o;

    // Drain control.
    logic                       stall_i;
    logic                       flush_i;

    // BHT write port, wired 1:1 to bp_fe_bht.
    logic                       w_v_o;
    logic [bht_idx_width_p-1:0] idx_w_o;
    logic                       correct_w_o;

    // Occupancy, 0..els_p.
    logic [ptr_width_lp:0]      count_o;

    modport master (
        output v_i, idx_i, correct_i, stall_i, flush_i,
        input  ready_o, w_v_o, idx_w_o, correct_w_o, count_o
    );

    modport slave (
        input  v_i, idx_i, correct_i, stall_i, flush_i,
        output ready_o, w_v_o, idx_w_o, correct_w_o, count_o
    );
endinterface

// File: rtl/bp_fe_bht_update_queue.sv
// Small circular FIFO that absorbs bursts of resolved-branch updates and
// feeds them to the single-ported BHT at most one per cycle. The BHT has no
// backpressure, so an asserted w_v_o is itself the dequeue. Pointers carry
// an extra wrap bit so full and empty are distinguishable without a counter.
module bp_fe_bht_update_queue #(
    parameter int bht_idx_width_p = 8,
    parameter int els_p           = 4
) (
    input logic                      clk_i,
    input logic                      reset_i,
    bp_fe_bht_update_queue_if.slave  upd
);
    localparam int ptr_width_lp = $clog2(els_p);
    localparam logic [ptr_width_lp:0] ptr_one_lp = (ptr_width_lp+1)'(1);

    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       correct;
    } entry_s;

    entry_s                mem_r [els_p];
    logic [ptr_width_lp:0] rptr_r;
    logic [ptr_width_lp:0] wptr_r;

    logic   empty;
    logic   full;
    logic   enq;
    logic   deq;
    entry_s head;

    assign empty = (rptr_r == wptr_r);
    assign full  = (rptr_r[ptr_width_lp-1:0] == wptr_r[ptr_width_lp-1:0])
                && (rptr_r[ptr_width_lp]     != wptr_r[ptr_width_lp]);

    // A flush swallows any same-cycle enqueue and blocks the drain.
    assign enq = upd.v_i & ~full & ~upd.flush_i;
    assign deq = ~empty & ~upd.stall_i & ~upd.flush_i;

    // ready depends only on registered state, never on a same-cycle dequeue.
    assign upd.ready_o = ~full;

    // Wrap-bit pointers make the subtraction naturally modulo 2*els_p.
    assign upd.count_o = wptr_r - rptr_r;

    assign head = mem_r[rptr_r[ptr_width_lp-1:0]];

    // Pointer state: flush collapses the queue by snapping rptr onto wptr.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_r <= '0;
            wptr_r <= '0;
        end else if (upd.flush_i) begin
            rptr_r <= wptr_r;
        end else begin
            if (enq) wptr_r <= wptr_r + ptr_one_lp;
            if (deq) rptr_r <= rptr_r + ptr_one_lp;
        end
    end

    // Entry storage, written at the tail on each accepted update.
    // NOTE: the data array is deliberately not reset; the pointers alone
    // decide which entries are live, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wptr_r[ptr_width_lp-1:0]] <= '{idx: upd.idx_i, correct: upd.correct_i};
        end
    end

    // Write-port drive: present the head whenever occupied, zero otherwise.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        upd.w_v_o       = 1'b0;
        upd.idx_w_o     = '0;
        upd.correct_w_o = 1'b0;
        if (!empty) begin
            upd.idx_w_o     = head.idx;
            upd.correct_w_o = head.correct;
            upd.w_v_o       = ~upd.stall_i & ~upd.flush_i;
        end
    end

`ifndef SYNTHESIS
    // Accepting while full would overwrite the oldest live entry.
    a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(enq && full))
        else $error("enqueue while full");

    // Occupancy can never exceed the storage depth.
    a_count_bounded: assert property (@(posedge clk_i) disable iff (reset_i)
        upd.count_o <= (ptr_width_lp+1)'(els_p))
        else $error("count_o exceeds els_p");

    // Wrap-bit pointer arithmetic only works for power-of-two depths >= 2.
    a_els_pow2: assert property (@(posedge clk_i)
        (els_p >= 2) && ((els_p & (els_p - 1)) == 0))
        else $error("els_p must be a power of two >= 2");
`endif

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Scoreboard bench for the BHT update queue. Accepted updates are pushed
// into an expected-write queue at the accepting edge; a negedge monitor
// compares the DUT's write port, occupancy and ready against that queue.
module tb_bp_fe_bht_update_queue;
    localparam int IW  = 8;
    localparam int ELS = 4;

    typedef struct {
        logic [IW-1:0] idx;
        logic          correct;
    } upd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int nchecks = 0;
    int nerrors = 0;

    upd_t exp_q[$];
    int   occ_seen = 0;

    always #5 clk = ~clk;

    bp_fe_bht_update_queue_if #(.bht_idx_width_p(IW), .els_p(ELS)) upd ();

    bp_fe_bht_update_queue #(.bht_idx_width_p(IW), .els_p(ELS)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .upd     (upd.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending updates with capacity ELS.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else if (upd.flush_i) begin
            exp_q.delete();
        end else if (upd.v_i && occ_seen < ELS) begin
            exp_q.push_back('{idx: upd.idx_i, correct: upd.correct_i});
        end
    end

    // Monitor: compare observable state mid-cycle and retire drained entries.
    always @(negedge clk) begin
        upd_t e;
        logic exp_wv;
        if (rst) begin
            occ_seen = 0;
            check("rst_count", upd.count_o, 0);
            check("rst_ready", upd.ready_o, 1);
            check("rst_w_v", upd.w_v_o, 0);
            check("rst_idx_w", upd.idx_w_o, 0);
            check("rst_correct_w", upd.correct_w_o, 0);
        end else begin
            occ_seen = exp_q.size();
            exp_wv   = (occ_seen > 0) && !upd.stall_i && !upd.flush_i;
            check("count", upd.count_o, occ_seen);
            check("ready", upd.ready_o, occ_seen < ELS);
            check("w_v", upd.w_v_o, exp_wv);
            if (exp_wv) begin
                e = exp_q.pop_front();
                check("idx_w", upd.idx_w_o, e.idx);
                check("correct_w", upd.correct_w_o, e.correct);
            end
        end
    end

    // Apply one cycle of stimulus, then step to just after the next edge.
    task automatic cycle(input logic v, input logic [IW-1:0] idx, input logic c,
                         input logic stall, input logic flush);
        upd.v_i       = v;
        upd.idx_i     = idx;
        upd.correct_i = c;
        upd.stall_i   = stall;
        upd.flush_i   = flush;
        @(posedge clk);
        #1;
    endtask

    initial begin
        upd.v_i = 0; upd.idx_i = '0; upd.correct_i = 0;
        upd.stall_i = 0; upd.flush_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset.
        repeat (10) cycle(0, 0, 0, 0, 0);

        // Single update appears the cycle after acceptance, then queue empties.
        cycle(1, 8'd5, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);

        // Fill under stall, fifth update dropped, then drain in order.
        for (int i = 1; i <= 4; i++) cycle(1, IW'(i), i[0], 1, 0);
        cycle(1, 8'd9, 1, 1, 0);
        repeat (6) cycle(0, 0, 0, 0, 0);

        // Continuous stream: occupancy stays at one, pointers wrap repeatedly.
        for (int i = 0; i < 20; i++) cycle(1, IW'(20 + i), i[0], 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);

        // Flush with three pending and a concurrent update.
        for (int i = 0; i < 3; i++) cycle(1, IW'(40 + i), 1, 1, 0);
        cycle(1, 8'd99, 1, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Asynchronous reset while draining two entries.
        for (int i = 0; i < 2; i++) cycle(1, IW'(50 + i), 0, 1, 0);
        upd.v_i = 0; upd.stall_i = 0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_count", upd.count_o, 0);
        check("async_rst_w_v", upd.w_v_o, 0);
        check("async_rst_ready", upd.ready_o, 1);
        check("async_rst_idx_w", upd.idx_w_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) cycle(0, 0, 0, 0, 0);

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 60,
                  IW'($urandom),
                  1'($urandom),
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 3);
        end
        repeat (8) cycle(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
